// File: rtl/regfile_dump_pkg.sv
// Shared types for the register-file dump/restore port: command opcode and FSM state.
package regfile_pkg;
    typedef enum logic {
        OP_DUMP = 1'b0,
        OP_LOAD = 1'b1
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DUMP_RD,
        S_DUMP_TX,
        S_LOAD,
        S_DONE
    } state_t;
endpackage

// File: rtl/regfile_dump_if.sv
// Host command/stream handshakes plus the register-file ports of regfile_dump.
interface regfile_dump_if
    import regfile_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int COUNT     = 32
);
    localparam int COUNT_BITS = $clog2(COUNT);

    logic                  cmd_valid;
    logic                  cmd_ready;
    op_t                   cmd_op;
    logic [COUNT_BITS-1:0] cmd_start;
    logic [COUNT_BITS:0]   cmd_len;
    logic                  out_valid;
    logic                  out_ready;
    logic [WORD_SIZE-1:0]  out_data;
    logic [COUNT_BITS-1:0] out_idx;
    logic                  out_last;
    logic                  in_valid;
    logic                  in_ready;
    logic [WORD_SIZE-1:0]  in_data;
    logic [WORD_SIZE-1:0]  rf_data_in;
    logic [COUNT_BITS-1:0] rf_idx_write;
    logic                  rf_en_write;
    logic [COUNT_BITS-1:0] rf_idx_read;
    logic [WORD_SIZE-1:0]  rf_data_read;
    logic                  busy;
    logic                  done;

    modport slave (
        input  cmd_valid, cmd_op, cmd_start, cmd_len, out_ready, in_valid, in_data, rf_data_read,
        output cmd_ready, out_valid, out_data, out_idx, out_last, in_ready,
               rf_data_in, rf_idx_write, rf_en_write, rf_idx_read, busy, done
    );

    modport master (
        output cmd_valid, cmd_op, cmd_start, cmd_len, out_ready, in_valid, in_data, rf_data_read,
        input  cmd_ready, out_valid, out_data, out_idx, out_last, in_ready,
               rf_data_in, rf_idx_write, rf_en_write, rf_idx_read, busy, done
    );
endinterface

// File: rtl/regfile_dump_idx_wrap_ctr.sv
// Loadable modulo-COUNT index counter; wraps COUNT-1 -> 0 for any COUNT.
module idx_wrap_ctr #(
    parameter  int COUNT      = 32,
    localparam int COUNT_BITS = $clog2(COUNT)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic [COUNT_BITS-1:0] i_load_val,
    input  logic                  i_inc,
    output logic [COUNT_BITS-1:0] o_idx
);
    localparam logic [COUNT_BITS:0]   LP_COUNT = (COUNT_BITS + 1)'(COUNT);
    localparam logic [COUNT_BITS-1:0] LP_MAX   = COUNT_BITS'(COUNT - 1);
    localparam logic [COUNT_BITS-1:0] LP_ONE   = COUNT_BITS'(1);

    logic [COUNT_BITS-1:0] r_idx;
    logic [COUNT_BITS-1:0] w_load_mod;

    // Load values are below 2*COUNT, so one conditional subtraction is a full modulo.
    assign w_load_mod = ({1'b0, i_load_val} >= LP_COUNT)
                      ? (i_load_val - LP_COUNT[COUNT_BITS-1:0]) : i_load_val;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx <= '0;
        end else if (i_load) begin
            r_idx <= w_load_mod;
        end else if (i_inc) begin
            r_idx <= (r_idx == LP_MAX) ? '0 : (r_idx + LP_ONE);
        end
    end

    assign o_idx = r_idx;
endmodule

// File: rtl/regfile_dump.sv
// Register-file dump/restore streaming port. Optional write protection: define
// REGFILE_DUMP_WPROT_EN to add wprot_mask/wprot_hit.
module regfile_dump
    import regfile_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int COUNT     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_dump_if.slave         bus
`ifdef REGFILE_DUMP_WPROT_EN
    ,
    input  logic [COUNT-1:0]      wprot_mask,
    output logic                  wprot_hit
`endif
);
    localparam int                  COUNT_BITS = $clog2(COUNT);
    localparam logic [COUNT_BITS:0] LP_COUNT   = (COUNT_BITS + 1)'(COUNT);
    localparam logic [COUNT_BITS:0] LP_REM_ONE = (COUNT_BITS + 1)'(1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [COUNT_BITS:0]   r_rem;
    logic [COUNT_BITS:0]   w_len;
    logic [COUNT_BITS-1:0] w_idx;
    logic                  w_accept;
    logic                  w_advance;
    logic                  w_tx_hs;
    logic                  w_wr_hs;
    logic                  w_prot;
    logic                  w_rem_last;
    logic                  r_out_valid;
    logic [WORD_SIZE-1:0]  r_out_data;
    logic [COUNT_BITS-1:0] r_out_idx;
    logic                  r_out_last;

    assign w_len      = (bus.cmd_len > LP_COUNT) ? LP_COUNT : bus.cmd_len;
    assign w_rem_last = (r_rem == LP_REM_ONE);

    idx_wrap_ctr #(.COUNT(COUNT)) u_idx (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_load     (w_accept),
        .i_load_val (bus.cmd_start),
        .i_inc      (w_advance),
        .o_idx      (w_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_accept        = 1'b0;
        w_advance       = 1'b0;
        w_tx_hs         = 1'b0;
        w_wr_hs         = 1'b0;
        bus.cmd_ready   = 1'b0;
        bus.in_ready    = 1'b0;
        bus.busy        = 1'b1;
        bus.done        = 1'b0;
        bus.rf_idx_read = '0;
        case (r_state)
            S_IDLE: begin
                bus.cmd_ready = 1'b1;
                bus.busy      = 1'b0;
                if (bus.cmd_valid) begin
                    w_accept = 1'b1;
                    if (bus.cmd_len == '0)         w_state_nxt = S_DONE;
                    else if (bus.cmd_op == OP_LOAD) w_state_nxt = S_LOAD;
                    else                            w_state_nxt = S_DUMP_RD;
                end
            end
            S_DUMP_RD: begin
                bus.rf_idx_read = w_idx;
                w_state_nxt     = S_DUMP_TX;
            end
            S_DUMP_TX: begin
                if (bus.out_ready) begin
                    w_tx_hs = 1'b1;
                    if (w_rem_last) w_state_nxt = S_DONE;
                    else begin
                        w_advance   = 1'b1;
                        w_state_nxt = S_DUMP_RD;
                    end
                end
            end
            S_LOAD: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_wr_hs = 1'b1;
                    if (w_rem_last) w_state_nxt = S_DONE;
                    else            w_advance   = 1'b1;
                end
            end
            S_DONE: begin
                bus.done    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rem       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_accept)       r_rem <= w_len;
            else if (w_advance) r_rem <= r_rem - LP_REM_ONE;
            if (r_state == S_DUMP_RD) begin
                r_out_valid <= 1'b1;
                r_out_data  <= bus.rf_data_read;
                r_out_idx   <= w_idx;
                r_out_last  <= w_rem_last;
            end else if (w_tx_hs) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef REGFILE_DUMP_WPROT_EN
    logic r_wprot_hit;

    assign w_prot = wprot_mask[w_idx];

    // Sticky until the next command is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                   r_wprot_hit <= 1'b0;
        else if (w_accept)          r_wprot_hit <= 1'b0;
        else if (w_wr_hs && w_prot) r_wprot_hit <= 1'b1;
    end

    assign wprot_hit = r_wprot_hit;
`else
    assign w_prot = 1'b0;
`endif

    assign bus.out_valid    = r_out_valid;
    assign bus.out_data     = r_out_data;
    assign bus.out_idx      = r_out_idx;
    assign bus.out_last     = r_out_last;
    assign bus.rf_en_write  = w_wr_hs & ~w_prot;
    assign bus.rf_idx_write = w_wr_hs ? w_idx : '0;
    assign bus.rf_data_in   = w_wr_hs ? bus.in_data : '0;
endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump with a behavioural register file on its rf_* ports.
module tb_regfile_dump;
    import regfile_pkg::*;

    localparam int WS  = 16;
    localparam int CNT = 32;
    localparam int CB  = $clog2(CNT);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_dump_if #(.WORD_SIZE(WS), .COUNT(CNT)) bus ();

`ifdef REGFILE_DUMP_WPROT_EN
    logic [CNT-1:0] wprot_mask;
    logic           wprot_hit;
`endif

    regfile_dump #(.WORD_SIZE(WS), .COUNT(CNT)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus)
`ifdef REGFILE_DUMP_WPROT_EN
        ,
        .wprot_mask (wprot_mask),
        .wprot_hit  (wprot_hit)
`endif
    );

    function automatic logic [WS-1:0] pat(input int i);
        return WS'(16'h1111 * (i + 1));
    endfunction

    // Register file model: combinational read, write on rising edge.
    logic [WS-1:0] rf_mem [CNT];
    logic [WS-1:0] exp_mem [CNT];
    logic          tb_init;
    logic          clr_log;
    int            wr_cnt;
    int            wr_log [16];

    assign bus.rf_data_read = rf_mem[bus.rf_idx_read];

    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < CNT; i++) rf_mem[i] <= pat(i);
        end else if (bus.rf_en_write) begin
            rf_mem[bus.rf_idx_write] <= bus.rf_data_in;
        end
        if (clr_log) begin
            wr_cnt <= 0;
        end else if (bus.rf_en_write && !tb_init) begin
            if (wr_cnt < 16) wr_log[wr_cnt] <= int'(bus.rf_idx_write);
            wr_cnt <= wr_cnt + 1;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input op_t op, input int start, input int len);
        bus.cmd_op    = op;
        bus.cmd_start = CB'(start);
        bus.cmd_len   = (CB + 1)'(len);
        bus.cmd_valid = 1'b1;
        #1;
        chk("cmd_ready_idle", bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic do_dump(input string tag, input int start, input int len,
                           input int stall_word, input int stall_n, output int done_cyc);
        int            nexp;
        int            k;
        int            cyc;
        int            stall_left;
        logic [WS-1:0] hold_d;
        logic [CB-1:0] hold_i;
        nexp       = (len > CNT) ? CNT : len;
        k          = 0;
        cyc        = 1;
        stall_left = stall_n;
        done_cyc   = -1;
        hold_d     = '0;
        hold_i     = '0;
        send_cmd(OP_DUMP, start, len);
        chk({tag, "_busy"}, bus.busy, 1);
        chk({tag, "_no_accept_busy"}, bus.cmd_ready, 0);
        while (cyc < 200 && done_cyc < 0) begin
            if (bus.out_valid && k == stall_word && stall_left > 0) begin
                bus.out_ready = 1'b0;
                if (stall_left == stall_n) begin
                    hold_d = bus.out_data;
                    hold_i = bus.out_idx;
                end else begin
                    chk({tag, "_stall_data"}, bus.out_data, hold_d);
                    chk({tag, "_stall_idx"}, bus.out_idx, hold_i);
                end
                stall_left--;
            end else begin
                bus.out_ready = 1'b1;
            end
            #1;
            if (bus.out_valid && bus.out_ready) begin
                chk({tag, "_data"}, bus.out_data, exp_mem[(start + k) % CNT]);
                chk({tag, "_idx"}, bus.out_idx, (start + k) % CNT);
                chk({tag, "_last"}, bus.out_last, (k == nexp - 1));
                k++;
            end
            if (bus.done) done_cyc = cyc;
            tick();
            cyc++;
        end
        bus.out_ready = 1'b1;
        chk({tag, "_done_seen"}, (done_cyc >= 0), 1);
        chk({tag, "_words"}, k, nexp);
        chk({tag, "_cmd_ready_after_done"}, bus.cmd_ready, 1);
        chk({tag, "_busy_after_done"}, bus.busy, 0);
    endtask

    task automatic load_word(input string tag, input logic [WS-1:0] data, input int gap,
                             input int exp_idx, input logic exp_en);
        repeat (gap) begin
            bus.in_valid = 1'b0;
            #1;
            chk({tag, "_gap_in_ready"}, bus.in_ready, 1);
            chk({tag, "_gap_no_write"}, bus.rf_en_write, 0);
            tick();
        end
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        #1;
        chk({tag, "_in_ready"}, bus.in_ready, 1);
        chk({tag, "_en_write"}, bus.rf_en_write, exp_en);
        chk({tag, "_idx_write"}, bus.rf_idx_write, exp_idx);
        chk({tag, "_data_in"}, bus.rf_data_in, data);
        tick();
        bus.in_valid = 1'b0;
    endtask

    int dc;

    initial begin
        rst           = 1'b0;
        tb_init       = 1'b1;
        clr_log       = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_DUMP;
        bus.cmd_start = '0;
        bus.cmd_len   = '0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
`ifdef REGFILE_DUMP_WPROT_EN
        wprot_mask = '0;
`endif
        for (int i = 0; i < CNT; i++) exp_mem[i] = pat(i);
        tick();
        tick();
        // Reset values
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_idx", bus.out_idx, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_en_write", bus.rf_en_write, 0);
        chk("rst_idx_write", bus.rf_idx_write, 0);
        chk("rst_data_in", bus.rf_data_in, 0);
        chk("rst_idx_read", bus.rf_idx_read, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
`ifdef REGFILE_DUMP_WPROT_EN
        chk("rst_wprot_hit", wprot_hit, 0);
`endif
        tb_init = 1'b0;
        clr_log = 1'b0;
        rst     = 1'b1;
        tick();

        do_dump("dump0", 0, 4, -1, 0, dc);
        chk("dump0_cycles", dc, 9);

        do_dump("dump30", 30, 4, -1, 0, dc);
        chk("dump30_cycles", dc, 9);

        do_dump("dumpstall", 30, 4, 2, 5, dc);
        chk("dumpstall_cycles", dc, 14);

        // LOAD 5..7 with gaps in in_valid
        send_cmd(OP_LOAD, 5, 3);
        load_word("ld0", 16'hAAAA, 0, 5, 1'b1);
        load_word("ld1", 16'hBBBB, 2, 6, 1'b1);
        load_word("ld2", 16'hCCCC, 1, 7, 1'b1);
        chk("ld_done", bus.done, 1);
        chk("ld_done_in_ready", bus.in_ready, 0);
        tick();
        chk("ld_cmd_ready_back", bus.cmd_ready, 1);
        chk("ld_wr_cnt", wr_cnt, 3);
        chk("ld_wr_idx0", wr_log[0], 5);
        chk("ld_wr_idx1", wr_log[1], 6);
        chk("ld_wr_idx2", wr_log[2], 7);
        exp_mem[5] = 16'hAAAA;
        exp_mem[6] = 16'hBBBB;
        exp_mem[7] = 16'hCCCC;
        chk("ld_rf5", rf_mem[5], 16'hAAAA);
        chk("ld_rf6", rf_mem[6], 16'hBBBB);
        chk("ld_rf7", rf_mem[7], 16'hCCCC);

        do_dump("readback", 5, 3, -1, 0, dc);
        chk("readback_cycles", dc, 7);

        // Zero-length command
        send_cmd(OP_LOAD, 3, 0);
        chk("len0_done", bus.done, 1);
        chk("len0_out_valid", bus.out_valid, 0);
        chk("len0_in_ready", bus.in_ready, 0);
        tick();
        chk("len0_cmd_ready", bus.cmd_ready, 1);
        chk("len0_no_write", wr_cnt, 3);

        do_dump("len40", 0, 40, -1, 0, dc);
        chk("len40_cycles", dc, 65);

        // Reset during the third word of a LOAD
        clr_log = 1'b1;
        tick();
        clr_log = 1'b0;
        send_cmd(OP_LOAD, 10, 8);
        load_word("rl0", 16'h1010, 0, 10, 1'b1);
        load_word("rl1", 16'h2020, 0, 11, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h3030;
        #1;
        rst = 1'b0;
        #1;
        chk("rl_busy", bus.busy, 0);
        chk("rl_en_write", bus.rf_en_write, 0);
        chk("rl_in_ready", bus.in_ready, 0);
        chk("rl_cmd_ready", bus.cmd_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        tick();
        chk("rl_wr_cnt", wr_cnt, 2);
        chk("rl_rf10", rf_mem[10], 16'h1010);
        chk("rl_rf11", rf_mem[11], 16'h2020);
        chk("rl_rf12", rf_mem[12], pat(12));
        exp_mem[10] = 16'h1010;
        exp_mem[11] = 16'h2020;

`ifdef REGFILE_DUMP_WPROT_EN
        wprot_mask    = '0;
        wprot_mask[6] = 1'b1;
        clr_log       = 1'b1;
        tick();
        clr_log = 1'b0;
        send_cmd(OP_LOAD, 5, 3);
        chk("wp_hit_clear", wprot_hit, 0);
        load_word("wp0", 16'h5555, 0, 5, 1'b1);
        load_word("wp1", 16'h6666, 0, 6, 1'b0);
        load_word("wp2", 16'h7777, 1, 7, 1'b1);
        chk("wp_hit_set", wprot_hit, 1);
        tick();
        chk("wp_wr_cnt", wr_cnt, 2);
        chk("wp_wr_idx0", wr_log[0], 5);
        chk("wp_wr_idx1", wr_log[1], 7);
        chk("wp_rf6_kept", rf_mem[6], 16'hBBBB);
        chk("wp_rf7", rf_mem[7], 16'h7777);
        chk("wp_hit_sticky", wprot_hit, 1);
        send_cmd(OP_DUMP, 0, 0);
        chk("wp_hit_cleared", wprot_hit, 0);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/regfile_dump.md
# regfile_dump

Streaming debug port that is the initiator for the CPU register file: on command it either reads a contiguous range of registers and streams them out, or streams words in and writes them into a range. It drives the register file's write port (data, index, write enable) and one read index, and consumes that read port's combinational data. It sits between the debug/host link and the register file, and is used for state dump/restore.

## Interface
- WORD_SIZE, 16, register width in bits
- COUNT, 32, number of registers
- COUNT_BITS, $clog2(COUNT), localparam, index width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cmd_valid / cmd_ready  in / out  1  command handshake
- cmd_op  in  1  0 = DUMP, 1 = LOAD
- cmd_start  in  COUNT_BITS  first register index
- cmd_len  in  COUNT_BITS+1  register count, 0..COUNT
- out_valid / out_ready  out / in  1  dump stream handshake
- out_data  out  WORD_SIZE  dumped word
- out_idx  out  COUNT_BITS  index of out_data
- out_last  out  1  final word of the command
- in_valid / in_ready  in / out  1  load stream handshake
- in_data  in  WORD_SIZE  word to load
- rf_data_in  out  WORD_SIZE  to register file write data
- rf_idx_write  out  COUNT_BITS  to register file write index
- rf_en_write  out  1  to register file write enable
- rf_idx_read  out  COUNT_BITS  to register file read index
- rf_data_read  in  WORD_SIZE  from register file read data (combinational)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at command completion

## Operation
- FSM states: IDLE, DUMP_RD, DUMP_TX, LOAD, DONE.
- IDLE: cmd_ready=1. On cmd_valid: latch the op, set idx=cmd_start and rem=cmd_len. If cmd_len==0, go to DONE. Otherwise go to DUMP_RD or LOAD according to cmd_op.
- DUMP_RD: rf_idx_read=idx. Register rf_data_read into out_data and idx into out_idx. Set out_last=(rem==1) and out_valid=1. Go to DUMP_TX.
- DUMP_TX: hold out_valid, out_data, out_idx and out_last stable until out_ready. On the handshake, clear out_valid. If rem==1, go to DONE; otherwise idx++, rem--, go to DUMP_RD.
- LOAD: in_ready=1. On in_valid, in the same cycle: rf_en_write=1, rf_idx_write=idx, rf_data_in=in_data. If rem==1, go to DONE; otherwise idx++, rem--.
- DONE: done=1 for one cycle, then go to IDLE.
- Index arithmetic wraps: COUNT-1 increments to 0 for any COUNT, power of two or not.
- cmd_len > COUNT is clamped to COUNT.
- cmd_start >= COUNT is reduced by taking it modulo COUNT.
- rf_en_write is 0 in every state except LOAD with in_valid.
- in_ready is 0 in every state except LOAD.
- Commands are not accepted while busy.

## Timing
- Reset values: cmd_ready=1, out_valid=0, out_data=0, out_idx=0, out_last=0, in_ready=0, rf_en_write=0, rf_idx_write=0, rf_data_in=0, rf_idx_read=0, busy=0, done=0.
- Command accept to first out_valid: 2 cycles. Dump throughput: 1 word per 2 cycles when out_ready is held high.
- Load: the write occurs in the handshake cycle. Throughput is 1 word per cycle. The first in_ready appears 1 cycle after command accept.
- done rises 1 cycle after the final handshake. cmd_ready returns 1 cycle after done.
- Reset asserted mid-command: immediately return to IDLE with all outputs at reset values. Load writes already performed remain in the register file; this block never resets it.

## Configuration
- Macro REGFILE_DUMP_WPROT_EN.
- Defined: adds input wprot_mask [COUNT-1:0] and output wprot_hit (1 bit, reset 0).
  - A load word whose idx has its mask bit set is still consumed (in_ready handshake completes), but rf_en_write stays 0.
  - wprot_hit is a sticky flag: set by any such suppressed write, cleared on the next command accept.
- Undefined: neither port exists and all load writes proceed.

## Structure
- Shared package regfile_pkg: the op typedef (OP_DUMP, OP_LOAD) and the state enum.
- One sub-module, idx_wrap_ctr: a loadable modulo-COUNT index counter with an increment enable.

## Test plan
- Reset, then DUMP start=0 len=4 over a file holding 0x1111..0x4444, out_ready=1 -> four words with out_idx 0..3 and out_last only on idx 3; done pulses; total 9 cycles from accept to done.
- DUMP start=30 len=4, COUNT=32 -> out_idx sequence 30, 31, 0, 1.
- Same dump with out_ready low for 5 cycles on word 2 -> out_data and out_idx stay stable throughout; no word is lost or duplicated.
- LOAD start=5 len=3 with in_data 0xAAAA, 0xBBBB, 0xCCCC and gaps in in_valid -> exactly three rf_en_write pulses at indices 5, 6, 7; a following dump reads those values back.
- cmd_len=0, then cmd_len=40 -> the first gives done 1 cycle after accept with no stream activity; the second transfers exactly 32 words.
- rst low during the third word of a len=8 LOAD -> busy=0 and rf_en_write=0 immediately; registers 0..1 of the range hold their new values. With REGFILE_DUMP_WPROT_EN and mask bit 6 set, a LOAD over 5..7 skips index 6 and sets wprot_hit.
